// File: rtl/add_arbiter.sv
// Round-robin front end for a shared external pipelined adder. Results come back through a
// credit-limited, in-order FIFO as {id, sum, cout}. Accept-to-response latency is LAT+1 cycles.
module add_arbiter #(
  parameter int WIDTH      = 32,
  parameter int NREQ       = 4,
  parameter int LAT        = WIDTH,
  parameter int FIFO_DEPTH = WIDTH + 4
) (
  input  logic                      clk,
  input  logic                      arst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*WIDTH-1:0]     req_a,
  input  logic [NREQ*WIDTH-1:0]     req_b,
  input  logic [NREQ-1:0]           req_cin,
  output logic [WIDTH-1:0]          add_a,
  output logic [WIDTH-1:0]          add_b,
  output logic                      add_cin,
  input  logic [WIDTH-1:0]          add_sum,
  input  logic                      add_cout,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [WIDTH-1:0]          rsp_sum,
  output logic                      rsp_cout,
  output logic                      busy
);

  localparam int IDW = $clog2(NREQ);
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int EW  = IDW + WIDTH + 1;

  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]  out_q, out_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LAT-1:0] tag_vld_q;
  logic [IDW-1:0] tag_id_q [LAT];
  logic [EW-1:0]  mem_q [FIFO_DEPTH];

  logic           gnt_vld;
  logic [IDW-1:0] gnt_id;
  logic [IDW:0]   cand;
  logic           credit_ok;
  logic           accept;
  logic           fifo_wr;
  logic           pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Walk from the highest offset down so the requester nearest rr_ptr wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    cand    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (req_valid[cand[IDW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_id  = cand[IDW-1:0];
      end
    end
  end

  assign credit_ok = (out_q < CW'(FIFO_DEPTH));
  assign accept    = gnt_vld & credit_ok & ~arst;
  assign req_ready = accept ? (NREQ'(1) << gnt_id) : '0;
  assign add_a     = accept ? req_a[int'(gnt_id)*WIDTH +: WIDTH] : '0;
  assign add_b     = accept ? req_b[int'(gnt_id)*WIDTH +: WIDTH] : '0;
  assign add_cin   = accept & req_cin[gnt_id];

  assign fifo_wr   = tag_vld_q[LAT-1];
  assign rsp_valid = (cnt_q != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign busy      = (out_q != '0);
  assign {rsp_id, rsp_sum, rsp_cout} = mem_q[rd_ptr_q];

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) rr_ptr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
    out_d    = out_q + CW'(accept) - CW'(pop);
    cnt_d    = cnt_q + CW'(fifo_wr) - CW'(pop);
    wr_ptr_d = fifo_wr ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      rr_ptr_q  <= '0;
      out_q     <= '0;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      tag_vld_q <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      out_q        <= out_d;
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      tag_vld_q[0] <= accept;
      for (int i = 1; i < LAT; i++) tag_vld_q[i] <= tag_vld_q[i-1];
    end
  end

  // Tag ids and FIFO payload are qualified by the reset valids, so they carry no reset.
  always_ff @(posedge clk) begin
    tag_id_q[0] <= gnt_id;
    for (int i = 1; i < LAT; i++) tag_id_q[i] <= tag_id_q[i-1];
    if (fifo_wr) mem_q[wr_ptr_q] <= {tag_id_q[LAT-1], add_sum, add_cout};
  end

endmodule

// File: tb/tb_add_arbiter.sv
// Randomized bench for add_arbiter: external adder pipeline plus a transaction-level model.
module tb_add_arbiter;
  localparam int WIDTH = 32, NREQ = 4, LAT = 32, FIFO_DEPTH = 36;

  logic                  clk, arst;
  logic [NREQ-1:0]       req_valid, req_ready, req_cin;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic [WIDTH-1:0]      add_a, add_b, add_sum, rsp_sum;
  logic                  add_cin, add_cout, rsp_valid, rsp_ready, rsp_cout, busy;
  logic [1:0]            rsp_id;

  add_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .LAT(LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .arst(arst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .busy(busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External adder: LAT register stages after operand capture.
  logic [WIDTH:0] pipe [LAT];
  initial for (int i = 0; i < LAT; i++) pipe[i] = '0;
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
    pipe[0] <= {1'b0, add_a} + {1'b0, add_b} + (WIDTH+1)'(add_cin);
  end
  assign add_sum  = pipe[LAT-1][WIDTH-1:0];
  assign add_cout = pipe[LAT-1][WIDTH];

  typedef struct {
    logic [1:0]       id;
    logic [WIDTH-1:0] sum;
    logic             cout;
    int               rdy;
  } rsp_t;

  rsp_t q[$];
  int   rr_m = 0, out_m = 0, cyc = 0;
  int   total = 0, bad = 0;

  function automatic int exp_grant();
    if (arst || out_m >= FIFO_DEPTH) return -1;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (rr_m + k) % NREQ;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic bit exp_rv();
    return !arst && q.size() > 0 && q[0].rdy <= cyc;
  endfunction

  function automatic logic [NREQ-1:0] exp_rdy();
    int g;
    g = exp_grant();
    return (g >= 0) ? (NREQ'(1) << g) : '0;
  endfunction

  task automatic model_clear();
    q.delete();
    rr_m  = 0;
    out_m = 0;
  endtask

  // Advance one clock, applying to the model whatever the current inputs imply.
  task automatic tick();
    int g;
    bit p;
    rsp_t r;
    logic [WIDTH:0] s;
    g = exp_grant();
    p = rsp_ready && exp_rv();
    @(posedge clk);
    if (p) void'(q.pop_front());
    if (g >= 0) begin
      s = {1'b0, req_a[g*WIDTH +: WIDTH]} + {1'b0, req_b[g*WIDTH +: WIDTH]} + (WIDTH+1)'(req_cin[g]);
      r.id = 2'(g); r.sum = s[WIDTH-1:0]; r.cout = s[WIDTH]; r.rdy = cyc + 1 + LAT;
      q.push_back(r);
      rr_m = (g + 1) % NREQ;
    end
    out_m = out_m + ((g >= 0) ? 1 : 0) - (p ? 1 : 0);
    cyc++;
    @(negedge clk);
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = ($urandom_range(0, 3) == 0) ? '1 : WIDTH'($urandom);
      req_b[i*WIDTH +: WIDTH] = WIDTH'($urandom);
      req_cin[i] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic drain();
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (LAT + FIFO_DEPTH + 4) tick();
  endtask

  task automatic test_reset();
    arst = 1'b1; req_valid = '1; rsp_ready = 1'b0; rand_ops();
    @(negedge clk); #1;
    total++; if (req_ready !== '0) begin bad++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if ({add_a, add_b, add_cin} !== '0) begin bad++; $display("FAIL reset_add_ops got=%h/%h/%b exp=0", add_a, add_b, add_cin); end
    tick();
    arst = 1'b0; req_valid = '0; model_clear();
    tick(); #1;
    total++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin bad++; $display("FAIL post_reset_idle busy=%b rsp_valid=%b exp=0/0", busy, rsp_valid); end
  endtask

  task automatic test_single_op();
    int n;
    req_valid = 4'b0010; rsp_ready = 1'b1;
    req_a[WIDTH +: WIDTH] = 32'hFFFF_FFFF; req_b[WIDTH +: WIDTH] = 32'h1; req_cin[1] = 1'b0;
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL single_grant got=%b exp=0010", req_ready); end
    total++; if (add_a !== 32'hFFFF_FFFF || add_b !== 32'h1 || add_cin !== 1'b0) begin bad++; $display("FAIL single_add_ops got=%h/%h/%b", add_a, add_b, add_cin); end
    tick();
    req_valid = '0;
    n = 1;
    #1;
    while (!rsp_valid && n < LAT + 10) begin tick(); n++; #1; end
    total++; if (n !== LAT + 1) begin bad++; $display("FAIL single_latency got=%0d exp=%0d", n, LAT + 1); end
    total++; if (rsp_id !== 2'd1 || rsp_sum !== 32'h0 || rsp_cout !== 1'b1) begin bad++; $display("FAIL single_result got=%0d/%h/%b exp=1/00000000/1", rsp_id, rsp_sum, rsp_cout); end
    tick();
    #1;
    total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL single_after_pop rsp_valid=%b busy=%b exp=0/0", rsp_valid, busy); end
  endtask

  task automatic test_round_robin();
    int r0;
    r0 = rr_m;
    rsp_ready = 1'b1; req_valid = '1;
    for (int k = 0; k < 20; k++) begin
      rand_ops(); #1;
      total++; if (req_ready !== (NREQ'(1) << ((r0 + k) % NREQ))) begin bad++; $display("FAIL rr_grant k=%0d got=%b exp_id=%0d", k, req_ready, (r0 + k) % NREQ); end
      tick();
    end
    req_valid = '0;
    for (int k = 0; k < LAT + 24; k++) begin
      #1;
      total++; if (rsp_valid !== exp_rv()) begin bad++; $display("FAIL rr_rsp_valid k=%0d got=%b exp=%b", k, rsp_valid, exp_rv()); end
      if (rsp_valid && q.size() > 0) begin
        total++; if ({rsp_id, rsp_sum, rsp_cout} !== {q[0].id, q[0].sum, q[0].cout}) begin bad++; $display("FAIL rr_rsp got=%0d/%h/%b exp=%0d/%h/%b", rsp_id, rsp_sum, rsp_cout, q[0].id, q[0].sum, q[0].cout); end
      end
      tick();
    end
    total++; if (q.size() !== 0 || busy !== 1'b0) begin bad++; $display("FAIL rr_drained left=%0d busy=%b exp=0/0", q.size(), busy); end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] ea;
    int g;
    for (int n = 0; n < 400; n++) begin
      req_valid = NREQ'($urandom); rsp_ready = ($urandom_range(0, 3) != 0); rand_ops();
      #1;
      g = exp_grant();
      ea = (g >= 0) ? req_a[g*WIDTH +: WIDTH] : '0;
      total++; if (req_ready !== exp_rdy()) begin bad++; $display("FAIL rand_grant n=%0d got=%b exp=%b", n, req_ready, exp_rdy()); end
      total++; if (add_a !== ea) begin bad++; $display("FAIL rand_add_a n=%0d got=%h exp=%h", n, add_a, ea); end
      total++; if (busy !== (out_m != 0)) begin bad++; $display("FAIL rand_busy n=%0d got=%b exp=%b", n, busy, out_m != 0); end
      total++; if (rsp_valid !== exp_rv()) begin bad++; $display("FAIL rand_rsp_valid n=%0d got=%b exp=%b", n, rsp_valid, exp_rv()); end
      if (rsp_valid && q.size() > 0) begin
        total++; if ({rsp_id, rsp_sum, rsp_cout} !== {q[0].id, q[0].sum, q[0].cout}) begin bad++; $display("FAIL rand_rsp n=%0d got=%0d/%h/%b exp=%0d/%h/%b", n, rsp_id, rsp_sum, rsp_cout, q[0].id, q[0].sum, q[0].cout); end
      end
      tick();
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int acc;
    acc = 0;
    rsp_ready = 1'b0; req_valid = '1;
    for (int n = 0; n < FIFO_DEPTH + LAT + 10; n++) begin
      rand_ops(); #1;
      if (req_ready != '0) acc++;
      total++; if (req_ready !== exp_rdy()) begin bad++; $display("FAIL bp_grant n=%0d got=%b exp=%b", n, req_ready, exp_rdy()); end
      tick();
    end
    total++; if (acc !== FIFO_DEPTH) begin bad++; $display("FAIL bp_accept_count got=%0d exp=%0d", acc, FIFO_DEPTH); end
    rsp_ready = 1'b1; #1;
    total++; if (req_ready !== '0 || rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_pop_cycle req_ready=%b rsp_valid=%b exp=0000/1", req_ready, rsp_valid); end
    total++; if ({rsp_id, rsp_sum, rsp_cout} !== {q[0].id, q[0].sum, q[0].cout}) begin bad++; $display("FAIL bp_pop_data got=%0d/%h exp=%0d/%h", rsp_id, rsp_sum, q[0].id, q[0].sum); end
    tick();
    rsp_ready = 1'b0; #1;
    total++; if (!$onehot(req_ready) || req_ready !== exp_rdy()) begin bad++; $display("FAIL bp_one_accept got=%b exp=%b", req_ready, exp_rdy()); end
    tick(); #1;
    total++; if (req_ready !== '0) begin bad++; $display("FAIL bp_full_again got=%b exp=0000", req_ready); end
    // Pop every cycle: accept and pop coincide at the full boundary and throughput holds.
    rsp_ready = 1'b1; tick();
    acc = 0;
    for (int n = 0; n < 60; n++) begin
      rand_ops(); #1;
      if (req_ready != '0) acc++;
      total++; if (rsp_valid !== 1'b1 || {rsp_id, rsp_sum, rsp_cout} !== {q[0].id, q[0].sum, q[0].cout}) begin bad++; $display("FAIL b2b_rsp n=%0d got=%b/%0d/%h exp=1/%0d/%h", n, rsp_valid, rsp_id, rsp_sum, q[0].id, q[0].sum); end
      tick();
    end
    total++; if (acc !== 60) begin bad++; $display("FAIL b2b_throughput got=%0d exp=60", acc); end
    drain();
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b0; req_valid = 4'b0001;
    repeat (5) begin rand_ops(); tick(); end
    req_valid = '0;
    repeat (LAT + 2) tick();
    req_valid = '1;
    repeat (10) begin rand_ops(); tick(); end
    #1;
    total++; if (q.size() !== 15 || rsp_valid !== 1'b1) begin bad++; $display("FAIL mid_setup outstanding=%0d rsp_valid=%b exp=15/1", q.size(), rsp_valid); end
    arst = 1'b1; model_clear(); #1;
    total++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== '0) begin bad++; $display("FAIL mid_reset rsp_valid=%b busy=%b req_ready=%b exp=0/0/0000", rsp_valid, busy, req_ready); end
    total++; if ({add_a, add_b, add_cin} !== '0) begin bad++; $display("FAIL mid_reset_add got=%h/%h/%b exp=0", add_a, add_b, add_cin); end
    tick(); tick();
    arst = 1'b0; req_valid = 4'b1000; rsp_ready = 1'b1; rand_ops(); #1;
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL only_req3 got=%b exp=1000", req_ready); end
    tick();
    req_valid = 4'b0001; #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rr_wrap_to0 got=%b exp=0001", req_ready); end
    tick();
    req_valid = 4'b0011; #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL rr_after0 got=%b exp=0010", req_ready); end
    tick();
    req_valid = '0;
    for (int k = 0; k < LAT + 8; k++) begin
      #1;
      total++; if (rsp_valid !== exp_rv()) begin bad++; $display("FAIL mid_stale k=%0d got=%b exp=%b", k, rsp_valid, exp_rv()); end
      if (rsp_valid && q.size() > 0) begin
        total++; if ({rsp_id, rsp_sum, rsp_cout} !== {q[0].id, q[0].sum, q[0].cout}) begin bad++; $display("FAIL mid_rsp got=%0d/%h exp=%0d/%h", rsp_id, rsp_sum, q[0].id, q[0].sum); end
      end
      tick();
    end
    total++; if (busy !== 1'b0 || q.size() !== 0) begin bad++; $display("FAIL mid_final busy=%b left=%0d exp=0/0", busy, q.size()); end
  endtask

  initial begin
    arst = 1'b1; req_valid = '0; rsp_ready = 1'b0; req_a = '0; req_b = '0; req_cin = '0;
    test_reset();
    test_single_op();
    test_round_robin();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
